// File: rtl/trig_buf_pkg.sv
// Shared types and widths for the trigger hold-off buffer.
// Holds the run-state encoding, word widths and the saturating drop-count step.
package trig_buf_pkg;

  localparam int TRIG_WORD_W = 32;
  localparam int DROP_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STOPPED = 2'd2
  } trig_buf_state_t;

  // Drop counter sticks at all-ones instead of wrapping back to zero.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/trig_buf_ram.sv
// DEPTH x W simple dual-port word store: synchronous write, combinational read
// that feeds the output register in the top level.
module trig_buf_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trig_holdoff_fifo.sv
// Trigger word buffer between the trigger generator and the TURF link: never
// backpressures, drops and counts words when full, spaces output handshakes by HOLDOFF.
module trig_holdoff_fifo
  import trig_buf_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int HOLDOFF = 4
) (
  input  logic                     ifclk,
  input  logic                     ifclk_rstn_i,
  input  logic                     runrst_i,
  input  logic                     runstop_i,
  input  logic [31:0]              s_trig_tdata,
  input  logic                     s_trig_tvalid,
  output logic                     s_trig_tready,
  output logic [31:0]              m_trig_tdata,
  output logic                     m_trig_tvalid,
  input  logic                     m_trig_tready,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [15:0]              drop_count_o,
  output logic                     overflow_o,
  output logic [1:0]               state_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [7:0]       HOLD_LOAD = 8'(HOLDOFF);

  // Handshake rules: s_trig is always ready out of reset, so any tvalid cycle is
  // a transfer (stored or dropped). On m_trig, once tvalid rises, tdata and
  // tvalid hold until a cycle with tready high; only runrst_i or reset withdraw it.

  trig_buf_state_t         state_q;
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;
  logic [7:0]              hold_q, hold_d;
  logic [DROP_CNT_W-1:0]   drop_q;
  logic                    ovf_q;
  logic                    valid_q;
  logic [TRIG_WORD_W-1:0]  data_q, ram_rd_data, head_d;
  logic                    offer, rd_fire, wr_fire, drop_fire, active_d;

  always_comb begin
    offer     = s_trig_tvalid && (state_q == ST_RUN) && !runrst_i;
    rd_fire   = valid_q && m_trig_tready;
    wr_fire   = offer && ((occ_q != OCC_FULL) || rd_fire);
    drop_fire = offer && !wr_fire;
    active_d  = runrst_i || (state_q != ST_IDLE);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    hold_d   = hold_q;
    if (runrst_i) begin
      rd_ptr_d = '0;
      occ_d    = '0;
      hold_d   = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_fire);
      case ({wr_fire, rd_fire})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
      if (rd_fire)          hold_d = HOLD_LOAD;
      else if (hold_q != 0) hold_d = hold_q - 1'b1;
    end
  end

  // A word written into the slot that becomes the new head is not in the RAM
  // yet, so it is forwarded straight into the output register.
  always_comb begin
    head_d = ram_rd_data;
    if (wr_fire && (rd_ptr_d == wr_ptr_q)) head_d = s_trig_tdata;
  end

  trig_buf_ram #(
    .DEPTH (DEPTH),
    .W     (TRIG_WORD_W)
  ) u_ram (
    .clk     (ifclk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr_q),
    .wr_data (s_trig_tdata),
    .rd_addr (rd_ptr_d),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge ifclk or negedge ifclk_rstn_i) begin
    if (!ifclk_rstn_i) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      hold_q   <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE:    if (runrst_i) state_q <= ST_RUN;
        ST_RUN:     if (!runrst_i && runstop_i) state_q <= ST_STOPPED;
        ST_STOPPED: if (runrst_i) state_q <= ST_RUN;
        default:    state_q <= ST_IDLE;
      endcase

      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      hold_q   <= hold_d;

      if (runrst_i) begin
        wr_ptr_q <= '0;
        drop_q   <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (drop_fire) begin
          drop_q <= sat_inc(drop_q);
          ovf_q  <= 1'b1;
        end
      end

      valid_q <= (occ_d != 0) && (hold_d == 0) && active_d;
      if (occ_d != 0) data_q <= head_d;
    end
  end

  assign s_trig_tready = ifclk_rstn_i;
  assign m_trig_tdata  = data_q;
  assign m_trig_tvalid = valid_q;
  assign occupancy_o   = occ_q;
  assign drop_count_o  = drop_q;
  assign overflow_o    = ovf_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_trig_holdoff_fifo.sv
// Self-checking bench for trig_holdoff_fifo: scenario tasks against a queue-based
// reference model, plus a HOLDOFF=0 instance for back-to-back output.
module tb_trig_holdoff_fifo;

  localparam int DEPTH   = 16;
  localparam int HOLDOFF = 4;
  localparam int OCC_W   = 5;

  logic              ifclk = 1'b0;
  logic              rstn;
  logic              runrst, runstop;
  logic [31:0]       s_tdata;
  logic              s_tvalid;
  logic              s_tready, s_tready_z;
  logic [31:0]       m_tdata, m_tdata_z;
  logic              m_tvalid, m_tvalid_z;
  logic              m_tready, m_tready_z;
  logic [OCC_W-1:0]  occ, occ_z;
  logic [15:0]       drop, drop_z;
  logic              ovf, ovf_z;
  logic [1:0]        state, state_z;

  always #5 ifclk = ~ifclk;

  trig_holdoff_fifo #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) u_dut (
    .ifclk(ifclk), .ifclk_rstn_i(rstn), .runrst_i(runrst), .runstop_i(runstop),
    .s_trig_tdata(s_tdata), .s_trig_tvalid(s_tvalid), .s_trig_tready(s_tready),
    .m_trig_tdata(m_tdata), .m_trig_tvalid(m_tvalid), .m_trig_tready(m_tready),
    .occupancy_o(occ), .drop_count_o(drop), .overflow_o(ovf), .state_o(state)
  );

  trig_holdoff_fifo #(.DEPTH(DEPTH), .HOLDOFF(0)) u_dut_z (
    .ifclk(ifclk), .ifclk_rstn_i(rstn), .runrst_i(runrst), .runstop_i(runstop),
    .s_trig_tdata(s_tdata), .s_trig_tvalid(s_tvalid), .s_trig_tready(s_tready_z),
    .m_trig_tdata(m_tdata_z), .m_trig_tvalid(m_tvalid_z), .m_trig_tready(m_tready_z),
    .occupancy_o(occ_z), .drop_count_o(drop_z), .overflow_o(ovf_z), .state_o(state_z)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: stored words in arrival order plus run statistics.
  logic [31:0] exp_q[$];
  int          exp_drops;
  bit          exp_ovf;
  int          exp_state;
  int          exp_hold;
  bit          exp_valid;

  task automatic model_reset();
    exp_q.delete();
    exp_drops = 0;
    exp_ovf   = 0;
    exp_state = 0;
    exp_hold  = 0;
    exp_valid = 0;
  endtask

  // Apply this cycle's inputs to the model, then advance one clock (negedge to negedge).
  task automatic tick();
    bit hs;
    hs = exp_valid && m_tready;
    if (runrst) begin
      exp_q.delete();
      exp_drops = 0;
      exp_ovf   = 0;
      exp_hold  = 0;
      exp_state = 1;
    end else begin
      if (hs) begin
        void'(exp_q.pop_front());
        exp_hold = HOLDOFF;
      end else if (exp_hold > 0) begin
        exp_hold--;
      end
      if (exp_state == 1 && s_tvalid) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(s_tdata);
        else begin
          if (exp_drops < 65535) exp_drops++;
          exp_ovf = 1;
        end
      end
      if (runstop && exp_state == 1) exp_state = 2;
    end
    exp_valid = (exp_state != 0) && (exp_q.size() != 0) && (exp_hold == 0);
    @(posedge ifclk);
    @(negedge ifclk);
    cyc++;
  endtask

  task automatic pulse_runrst();
    runrst = 1'b1;
    tick();
    runrst = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge ifclk);
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %0b want 0", s_tready); end
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b want 0", m_tvalid); end
    checks++; if (m_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    checks++; if (occ !== 5'd0 || drop !== 16'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL reset_stats: occ=%0d drop=%0d ovf=%0b want 0/0/0", occ, drop, ovf); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    rstn = 1'b1;
    model_reset();
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_tready_after: got %0b want 1", s_tready); end
    // Words offered in IDLE are neither stored nor counted.
    s_tvalid = 1'b1; s_tdata = 32'h1234_5678;
    tick();
    s_tvalid = 1'b0;
    checks++; if (occ !== 5'd0 || drop !== 16'd0 || state !== 2'd0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL idle_ignore: occ=%0d drop=%0d state=%0d valid=%0b want 0/0/0/0", occ, drop, state, m_tvalid); end
  endtask

  task automatic test_latency();
    pulse_runrst();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL latency_run: state=%0d want 1", state); end
    s_tdata = 32'hA5A5_0001; s_tvalid = 1'b1; m_tready = 1'b1;
    tick();
    s_tvalid = 1'b0;
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 32'hA5A5_0001) begin
      errors++; $display("FAIL latency_present: valid=%0b data=%h want 1/a5a50001", m_tvalid, m_tdata); end
    checks++; if (occ !== 5'd1) begin errors++; $display("FAIL latency_occ1: got %0d want 1", occ); end
    tick();
    checks++; if (occ !== 5'd0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL latency_drain: occ=%0d valid=%0b want 0/0", occ, m_tvalid); end
    m_tready = 1'b0;
    repeat (HOLDOFF) tick();
  endtask

  task automatic test_overflow();
    int got;
    pulse_runrst();
    m_tready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      s_tdata = 32'h0B00_0000 + 32'(i + 1); s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    checks++; if (occ !== 5'd16) begin errors++; $display("FAIL ovf_occ: got %0d want 16", occ); end
    checks++; if (drop !== 16'd4) begin errors++; $display("FAIL ovf_drops: got %0d want 4", drop); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", ovf); end
    m_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      if (m_tvalid) begin
        checks++; if (m_tdata !== 32'h0B00_0000 + 32'(got + 1)) begin
          errors++; $display("FAIL ovf_order[%0d]: got %h want %h", got, m_tdata, 32'h0B00_0000 + 32'(got + 1)); end
        got++;
      end
      tick();
    end
    checks++; if (got !== 16) begin errors++; $display("FAIL ovf_drain_count: got %0d want 16", got); end
    checks++; if (occ !== 5'd0 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_after_drain: occ=%0d ovf=%0b want 0/1", occ, ovf); end
    m_tready = 1'b0;
  endtask

  task automatic test_holdoff();
    int hs_c[$];
    int hs_cz[$];
    logic [31:0] dz[$];
    pulse_runrst();
    m_tready = 1'b0; m_tready_z = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_tdata = 32'h0C00_0001 + 32'(i); s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1; m_tready_z = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (m_tvalid) begin
        checks++; if (m_tdata !== 32'h0C00_0001 + 32'(hs_c.size())) begin
          errors++; $display("FAIL holdoff_data: got %h want %h", m_tdata, 32'h0C00_0001 + 32'(hs_c.size())); end
        hs_c.push_back(cyc);
      end
      if (m_tvalid_z) begin
        hs_cz.push_back(cyc);
        dz.push_back(m_tdata_z);
      end
      tick();
    end
    checks++; if (hs_c.size() !== 3 || hs_cz.size() !== 3) begin
      errors++; $display("FAIL holdoff_count: got %0d/%0d want 3/3", hs_c.size(), hs_cz.size()); end
    else begin
      for (int k = 1; k < 3; k++) begin
        checks++; if (hs_c[k] - hs_c[k-1] !== 5) begin
          errors++; $display("FAIL holdoff_gap[%0d]: got %0d want 5", k, hs_c[k] - hs_c[k-1]); end
        checks++; if (hs_cz[k] - hs_cz[k-1] !== 1) begin
          errors++; $display("FAIL holdoff0_gap[%0d]: got %0d want 1", k, hs_cz[k] - hs_cz[k-1]); end
      end
      for (int k = 0; k < 3; k++) begin
        checks++; if (dz[k] !== 32'h0C00_0001 + 32'(k)) begin
          errors++; $display("FAIL holdoff0_data[%0d]: got %h want %h", k, dz[k], 32'h0C00_0001 + 32'(k)); end
      end
    end
    m_tready = 1'b0; m_tready_z = 1'b0;
  endtask

  task automatic test_stop_drain();
    int got;
    pulse_runrst();
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_tdata = 32'h0D00_0001 + 32'(i); s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    runstop = 1'b1;
    tick();
    runstop = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL stop_state: got %0d want 2", state); end
    m_tready = 1'b1;
    got = 0;
    for (int c = 0; c < 40; c++) begin
      s_tvalid = 1'b1; s_tdata = $urandom;
      if (m_tvalid) begin
        checks++; if (m_tdata !== 32'h0D00_0001 + 32'(got)) begin
          errors++; $display("FAIL stop_order[%0d]: got %h want %h", got, m_tdata, 32'h0D00_0001 + 32'(got)); end
        got++;
      end
      tick();
    end
    s_tvalid = 1'b0;
    checks++; if (got !== 5) begin errors++; $display("FAIL stop_drain_count: got %0d want 5", got); end
    checks++; if (occ !== 5'd0 || drop !== 16'd0 || ovf !== 1'b0 || state !== 2'd2) begin
      errors++; $display("FAIL stop_after: occ=%0d drop=%0d ovf=%0b state=%0d want 0/0/0/2", occ, drop, ovf, state); end
    m_tready = 1'b0;
    pulse_runrst();
    checks++; if (state !== 2'd1 || occ !== 5'd0 || drop !== 16'd0) begin
      errors++; $display("FAIL stop_restart: state=%0d occ=%0d drop=%0d want 1/0/0", state, occ, drop); end
  endtask

  task automatic test_simultaneous();
    pulse_runrst();
    m_tready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_tdata = 32'h0E00_0001 + 32'(i); s_tvalid = 1'b1;
      tick();
    end
    checks++; if (occ !== 5'd16 || m_tvalid !== 1'b1) begin
      errors++; $display("FAIL simul_full: occ=%0d valid=%0b want 16/1", occ, m_tvalid); end
    m_tready = 1'b1; s_tdata = 32'h0E00_0011;
    tick();
    m_tready = 1'b0; s_tvalid = 1'b0;
    checks++; if (occ !== 5'd16 || drop !== 16'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL simul_rw: occ=%0d drop=%0d ovf=%0b want 16/0/0", occ, drop, ovf); end
    runrst = 1'b1; runstop = 1'b1;
    tick();
    runrst = 1'b0; runstop = 1'b0;
    checks++; if (state !== 2'd1 || occ !== 5'd0 || m_tvalid !== 1'b0) begin
      errors++; $display("FAIL simul_rst_stop: state=%0d occ=%0d valid=%0b want 1/0/0", state, occ, m_tvalid); end
    s_tvalid = 1'b1; s_tdata = 32'h0E00_00FF;
    tick();
    s_tvalid = 1'b0;
    checks++; if (occ !== 5'd1 || m_tdata !== 32'h0E00_00FF) begin
      errors++; $display("FAIL simul_accept: occ=%0d data=%h want 1/0e0000ff", occ, m_tdata); end
  endtask

  task automatic test_random();
    pulse_runrst();
    for (int c = 0; c < 400; c++) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = $urandom;
      m_tready = ($urandom_range(0, 2) == 0);
      runstop  = ($urandom_range(0, 99) == 0);
      runrst   = ($urandom_range(0, 149) == 0);
      checks++; if (m_tvalid !== exp_valid) begin
        errors++; $display("FAIL rand_valid@%0d: got %0b want %0b", cyc, m_tvalid, exp_valid); end
      if (exp_valid) begin
        checks++; if (m_tdata !== exp_q[0]) begin
          errors++; $display("FAIL rand_data@%0d: got %h want %h", cyc, m_tdata, exp_q[0]); end
      end
      checks++; if (occ !== OCC_W'(exp_q.size())) begin
        errors++; $display("FAIL rand_occ@%0d: got %0d want %0d", cyc, occ, exp_q.size()); end
      checks++; if (drop !== 16'(exp_drops) || ovf !== exp_ovf) begin
        errors++; $display("FAIL rand_stats@%0d: drop=%0d ovf=%0b want %0d/%0b", cyc, drop, ovf, exp_drops, exp_ovf); end
      checks++; if (state !== 2'(exp_state)) begin
        errors++; $display("FAIL rand_state@%0d: got %0d want %0d", cyc, state, exp_state); end
      tick();
    end
    s_tvalid = 1'b0; m_tready = 1'b0; runstop = 1'b0; runrst = 1'b0;
  endtask

  task automatic test_mid_reset();
    pulse_runrst();
    m_tready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      s_tdata = 32'h0F00_0001 + 32'(i); s_tvalid = 1'b1;
      tick();
    end
    checks++; if (m_tvalid !== 1'b1 || drop !== 16'd2) begin
      errors++; $display("FAIL midrst_pre: valid=%0b drop=%0d want 1/2", m_tvalid, drop); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 || s_tready !== 1'b0) begin
      errors++; $display("FAIL midrst_out: valid=%0b data=%h tready=%0b want 0/0/0", m_tvalid, m_tdata, s_tready); end
    checks++; if (occ !== 5'd0 || drop !== 16'd0 || ovf !== 1'b0 || state !== 2'd0) begin
      errors++; $display("FAIL midrst_stats: occ=%0d drop=%0d ovf=%0b state=%0d want 0/0/0/0", occ, drop, ovf, state); end
    @(negedge ifclk);
    s_tvalid = 1'b0;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic test_saturation();
    pulse_runrst();
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < DEPTH + 70000; i++) begin
      s_tdata = 32'(i);
      tick();
    end
    s_tvalid = 1'b0;
    checks++; if (drop !== 16'hFFFF || ovf !== 1'b1) begin
      errors++; $display("FAIL sat_drops: drop=%h ovf=%0b want ffff/1", drop, ovf); end
    checks++; if (occ !== 5'd16 || drop !== 16'(exp_drops)) begin
      errors++; $display("FAIL sat_model: occ=%0d drop=%0d want 16/%0d", occ, drop, exp_drops); end
  endtask

  initial begin
    rstn = 1'b0; runrst = 1'b0; runstop = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0; m_tready_z = 1'b0;
    model_reset();
    test_reset();
    test_latency();
    test_overflow();
    test_holdoff();
    test_stop_drain();
    test_simultaneous();
    test_random();
    test_mid_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
